// File: rtl/charge_accum_ctrl.sv
// Read-modify-write sequencer for the neuron charge RAM: arbitrates accumulate and
// clear/readout requests, forwards in-flight results, and zero-fills the RAM after reset.
module charge_accum_ctrl #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 16,
   parameter int WEIGHT_W       = 8,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                accum_valid,
   output logic                accum_ready,
   input  logic [ADDR_W-1:0]   accum_addr,
   input  logic [WEIGHT_W-1:0] accum_weight,
   input  logic                clr_valid,
   output logic                clr_ready,
   input  logic [ADDR_W-1:0]   clr_addr,
   output logic                out_valid,
   output logic [ADDR_W-1:0]   out_addr,
   output logic [DATA_W-1:0]   out_charge,
   output logic                init_done,
   output logic                ram_rd_en,
   output logic [ADDR_W-1:0]   ram_rd_addr,
   input  logic [DATA_W-1:0]   ram_rd_data,
   output logic                ram_wr_en,
   output logic [ADDR_W-1:0]   ram_wr_addr,
   output logic [DATA_W-1:0]   ram_wr_data
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Signed add of a sign-extended weight, clamped to the charge range.
   function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0]   a,
                                                 input logic [WEIGHT_W-1:0] w);
      logic [DATA_W:0]   sum;
      logic [DATA_W-1:0] res;
      sum = {a[DATA_W-1], a} + {{(DATA_W+1-WEIGHT_W){w[WEIGHT_W-1]}}, w};
      if (sum[DATA_W] != sum[DATA_W-1]) begin
         if (sum[DATA_W]) begin
            res = {1'b1, {(DATA_W-1){1'b0}}};
         end else begin
            res = {1'b0, {(DATA_W-1){1'b1}}};
         end
      end else begin
         res = sum[DATA_W-1:0];
      end
      return res;
   endfunction

   state_t                state_r;
   logic [ADDR_W-1:0]     sweep_cnt_r;
   logic                  rr_clr_r;
   logic                  init_done_r;

   logic                  s1_valid_r;
   logic                  s1_is_clr_r;
   logic [ADDR_W-1:0]     s1_addr_r;
   logic [WEIGHT_W-1:0]   s1_weight_r;

   logic                  wr_en_r;
   logic [ADDR_W-1:0]     wr_addr_r;
   logic [DATA_W-1:0]     wr_data_r;

   // Copy of the write that committed last cycle; a read issued alongside it saw stale data.
   logic                  cm_valid_r;
   logic [ADDR_W-1:0]     cm_addr_r;
   logic [DATA_W-1:0]     cm_data_r;

   logic                  out_valid_r;
   logic [ADDR_W-1:0]     out_addr_r;
   logic [DATA_W-1:0]     out_charge_r;

   logic                  accum_ready_s;
   logic                  clr_ready_s;
   logic                  take_accum_s;
   logic                  take_clr_s;
   logic                  rd_en_s;
   logic [ADDR_W-1:0]     rd_addr_s;
   logic [DATA_W-1:0]     operand_s;
   logic [DATA_W-1:0]     result_s;

   // Round-robin arbitration between the two requesters; only in RUN.
   always_comb begin
      accum_ready_s = 1'b0;
      clr_ready_s   = 1'b0;
      if (state_r == ST_RUN) begin
         if (accum_valid && clr_valid) begin
            accum_ready_s = !rr_clr_r;
            clr_ready_s   = rr_clr_r;
         end else if (clr_valid) begin
            clr_ready_s   = 1'b1;
         end else begin
            accum_ready_s = 1'b1;
         end
      end else begin
         accum_ready_s = 1'b0;
         clr_ready_s   = 1'b0;
      end
   end

   assign take_accum_s = accum_valid && accum_ready_s;
   assign take_clr_s   = clr_valid && clr_ready_s;
   assign rd_en_s      = take_accum_s || take_clr_s;
   assign rd_addr_s    = take_clr_s ? clr_addr : accum_addr;

   // S1 operand select: newest in-flight write wins over the RAM read data.
   always_comb begin
      operand_s = ram_rd_data;
      if (wr_en_r && (wr_addr_r == s1_addr_r)) begin
         operand_s = wr_data_r;
      end else if (cm_valid_r && (cm_addr_r == s1_addr_r)) begin
         operand_s = cm_data_r;
      end else begin
         operand_s = ram_rd_data;
      end
   end

   // S1 result: clear writes zero, accumulate writes the saturated sum.
   always_comb begin
      result_s = {DATA_W{1'b0}};
      if (s1_is_clr_r) begin
         result_s = {DATA_W{1'b0}};
      end else begin
         result_s = sat_add(operand_s, s1_weight_r);
      end
   end

   // Sweep/run FSM together with the S1, WB and commit-copy pipeline registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (CLEAR_ON_RESET) begin
            state_r <= ST_INIT;
         end else begin
            state_r <= ST_RUN;
         end
         sweep_cnt_r  <= {ADDR_W{1'b0}};
         rr_clr_r     <= 1'b0;
         init_done_r  <= 1'b0;
         s1_valid_r   <= 1'b0;
         s1_is_clr_r  <= 1'b0;
         s1_addr_r    <= {ADDR_W{1'b0}};
         s1_weight_r  <= {WEIGHT_W{1'b0}};
         wr_en_r      <= 1'b0;
         wr_addr_r    <= {ADDR_W{1'b0}};
         wr_data_r    <= {DATA_W{1'b0}};
         cm_valid_r   <= 1'b0;
         cm_addr_r    <= {ADDR_W{1'b0}};
         cm_data_r    <= {DATA_W{1'b0}};
         out_valid_r  <= 1'b0;
         out_addr_r   <= {ADDR_W{1'b0}};
         out_charge_r <= {DATA_W{1'b0}};
      end else begin
         cm_valid_r  <= wr_en_r;
         cm_addr_r   <= wr_addr_r;
         cm_data_r   <= wr_data_r;
         out_valid_r <= 1'b0;
         case (state_r)
            ST_INIT: begin
               wr_en_r     <= 1'b1;
               wr_addr_r   <= sweep_cnt_r;
               wr_data_r   <= {DATA_W{1'b0}};
               sweep_cnt_r <= sweep_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               s1_valid_r  <= 1'b0;
               if (sweep_cnt_r == {ADDR_W{1'b1}}) begin
                  state_r     <= ST_RUN;
                  init_done_r <= 1'b1;
               end else begin
                  state_r     <= ST_INIT;
               end
            end
            ST_RUN: begin
               init_done_r <= 1'b1;
               if (accum_valid && clr_valid) begin
                  rr_clr_r <= !rr_clr_r;
               end else begin
                  rr_clr_r <= rr_clr_r;
               end
               s1_valid_r  <= rd_en_s;
               s1_is_clr_r <= take_clr_s;
               s1_addr_r   <= rd_addr_s;
               s1_weight_r <= accum_weight;
               wr_en_r     <= s1_valid_r;
               wr_addr_r   <= s1_addr_r;
               wr_data_r   <= result_s;
               if (s1_valid_r && s1_is_clr_r) begin
                  out_valid_r  <= 1'b1;
                  out_addr_r   <= s1_addr_r;
                  out_charge_r <= operand_s;
               end else begin
                  out_valid_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_INIT;
            end
         endcase
      end
   end

   assign accum_ready = accum_ready_s;
   assign clr_ready   = clr_ready_s;
   assign ram_rd_en   = rd_en_s;
   assign ram_rd_addr = rd_addr_s;
   assign ram_wr_en   = wr_en_r;
   assign ram_wr_addr = wr_addr_r;
   assign ram_wr_data = wr_data_r;
   assign out_valid   = out_valid_r;
   assign out_addr    = out_addr_r;
   assign out_charge  = out_charge_r;
   assign init_done   = init_done_r;

endmodule

// File: tb/tb_charge_accum_ctrl.sv
// Directed bench for charge_accum_ctrl with a read-before-write RAM model.
module tb_charge_accum_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       accum_valid, accum_ready, clr_valid, clr_ready;
   logic [7:0] accum_addr, accum_weight, clr_addr;
   logic       out_valid, init_done, ram_rd_en, ram_wr_en;
   logic [7:0] out_addr, ram_rd_addr, ram_wr_addr;
   logic [15:0] out_charge, ram_rd_data, ram_wr_data;

   logic [15:0] mem [0:255];
   logic        pre_en;
   logic [7:0]  pre_addr;
   logic [15:0] pre_data;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int out_cnt = 0;
   int both_cnt = 0;
   int last_cyc = 0;
   int acc_cyc = 0;
   logic [7:0]  last_addr;
   logic [15:0] last_charge;

   charge_accum_ctrl dut (
      .clk(clk), .reset(reset),
      .accum_valid(accum_valid), .accum_ready(accum_ready),
      .accum_addr(accum_addr), .accum_weight(accum_weight),
      .clr_valid(clr_valid), .clr_ready(clr_ready), .clr_addr(clr_addr),
      .out_valid(out_valid), .out_addr(out_addr), .out_charge(out_charge),
      .init_done(init_done),
      .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
   );

   always #5 clk = ~clk;

   // RAM model: read returns the contents before this edge's write.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      if (pre_en) mem[pre_addr] <= pre_data;
   end

   // Readout and ready-exclusivity monitor.
   always @(negedge clk) begin
      if (out_valid) begin
         out_cnt     <= out_cnt + 1;
         last_addr   <= out_addr;
         last_charge <= out_charge;
         last_cyc    <= cyc;
      end
      if (accum_ready && clr_ready) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic drive(input logic av, input logic [7:0] aa, input logic [7:0] aw,
                        input logic cv, input logic [7:0] ca,
                        output logic ga, output logic gc);
      accum_valid = av; accum_addr = aa; accum_weight = aw;
      clr_valid = cv; clr_addr = ca;
      @(negedge clk);
      ga = av & accum_ready;
      gc = cv & clr_ready;
      acc_cyc = cyc;
      @(posedge clk); #1;
      accum_valid = 1'b0; clr_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   task automatic wait_sweep(input string tag);
      int  nwr, bad;
      bit  done;
      nwr = 0; bad = 0; done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (!init_done && (accum_ready || clr_ready)) bad++;
         if (ram_wr_en) begin
            if (ram_wr_addr != nwr[7:0] || ram_wr_data != 16'h0000) bad++;
            nwr++;
         end
         if (init_done) done = 1'b1;
      end
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_writes"}, nwr, 32'd256);
      chk({tag, "_bad"}, bad, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic ga, gc;
      int   o0, gsum, wr_bad;
      logic [5:0] seq_a, seq_c;
      logic [3:0] seq4;

      reset = 1'b0; pre_en = 1'b0; pre_addr = 8'd0; pre_data = 16'd0;
      accum_valid = 1'b0; clr_valid = 1'b0;
      accum_addr = 8'd0; accum_weight = 8'd0; clr_addr = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_accum_ready", {31'd0, accum_ready}, 32'd0);
      chk("rst_clr_ready", {31'd0, clr_ready}, 32'd0);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_wr_en", {31'd0, ram_wr_en}, 32'd0);
      chk("rst_out_charge", {16'd0, out_charge}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      wait_sweep("sweep");

      // Saturation at both ends of the charge range.
      preload(8'd7, 16'd32760);
      preload(8'd8, 16'h8008);
      drive(1'b1, 8'd7, 8'h7F, 1'b0, 8'd0, ga, gc);
      chk("sat_pos_grant", {31'd0, ga}, 32'd1);
      drive(1'b1, 8'd8, 8'h80, 1'b0, 8'd0, ga, gc);
      idle(3);
      chk("sat_pos", {16'd0, mem[7]}, 32'h7FFF);
      chk("sat_neg", {16'd0, mem[8]}, 32'h8000);

      // Back-to-back hazard on one address followed by a clear.
      o0 = out_cnt; gsum = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'd3, 8'd5, 1'b0, 8'd0, ga, gc);
         gsum += int'(ga);
      end
      drive(1'b0, 8'd0, 8'd0, 1'b1, 8'd3, ga, gc);
      gsum += int'(gc);
      idle(4);
      chk("hz_grants", gsum, 32'd4);
      chk("hz_pulses", out_cnt - o0, 32'd1);
      chk("hz_addr", {24'd0, last_addr}, 32'd3);
      chk("hz_charge", {16'd0, last_charge}, 32'd15);
      chk("hz_ram", {16'd0, mem[3]}, 32'd0);

      // Two-ahead forwarding via the committed-write copy.
      drive(1'b1, 8'd20, 8'd1, 1'b0, 8'd0, ga, gc);
      drive(1'b1, 8'd21, 8'd1, 1'b0, 8'd0, ga, gc);
      drive(1'b1, 8'd20, 8'd1, 1'b0, 8'd0, ga, gc);
      idle(3);
      chk("fwd2_a20", {16'd0, mem[20]}, 32'd2);
      chk("fwd2_a21", {16'd0, mem[21]}, 32'd1);

      // Readout latency and value.
      drive(1'b1, 8'd10, 8'd20, 1'b0, 8'd0, ga, gc);
      drive(1'b1, 8'd10, 8'hF9, 1'b0, 8'd0, ga, gc);
      idle(4);
      o0 = out_cnt;
      drive(1'b0, 8'd0, 8'd0, 1'b1, 8'd10, ga, gc);
      idle(4);
      chk("ro_pulses", out_cnt - o0, 32'd1);
      chk("ro_addr", {24'd0, last_addr}, 32'd10);
      chk("ro_charge", {16'd0, last_charge}, 32'd13);
      chk("ro_latency", last_cyc - acc_cyc, 32'd2);
      chk("ro_ram", {16'd0, mem[10]}, 32'd0);

      // Contention alternates, then a lone requester is granted every cycle.
      o0 = out_cnt; seq_a = 6'd0; seq_c = 6'd0; seq4 = 4'd0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'd30, 8'd1, 1'b1, 8'd31, ga, gc);
         seq_a = {seq_a[4:0], ga};
         seq_c = {seq_c[4:0], gc};
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'd30, 8'd1, 1'b0, 8'd0, ga, gc);
         seq4 = {seq4[2:0], ga};
      end
      idle(4);
      chk("arb_accum_seq", {26'd0, seq_a}, 32'b101010);
      chk("arb_clr_seq", {26'd0, seq_c}, 32'b010101);
      chk("arb_solo_seq", {28'd0, seq4}, 32'b1111);
      chk("arb_ram30", {16'd0, mem[30]}, 32'd7);
      chk("arb_pulses", out_cnt - o0, 32'd3);
      chk("arb_zero_charge", {16'd0, last_charge}, 32'd0);

      // Reset the cycle after a clear is accepted.
      drive(1'b1, 8'd10, 8'd9, 1'b0, 8'd0, ga, gc);
      idle(3);
      o0 = out_cnt; wr_bad = 0;
      drive(1'b0, 8'd0, 8'd0, 1'b1, 8'd10, ga, gc);
      chk("rm_clr_grant", {31'd0, gc}, 32'd1);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (ram_wr_en) wr_bad++;
         @(posedge clk); #1;
      end
      reset = 1'b1;
      wait_sweep("resweep");
      chk("rm_no_write", wr_bad, 32'd0);
      chk("rm_no_pulse", out_cnt - o0, 32'd0);
      chk("rm_ram10", {16'd0, mem[10]}, 32'd0);
      chk("ready_exclusive", both_cnt, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
